// File: rtl/timer_pkg.sv
// Shared types for the countdown timer: FSM state, BCD digit type and clamp helper.
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSE,
      ST_EXPIRED
   } timer_state_t;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;

   // Out-of-range BCD nibbles (A..F) saturate to 9 rather than wrap.
   function automatic bcd_t bcd_clamp(input bcd_t d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/timer_ctrl_tick_gen.sv
// Prescaler: counts 0..PERIOD-1 while enabled, one-cycle tick on wrap plus a
// half-period tick (mid-count and wrap) used for blinking. PERIOD must be >= 2.
module tick_gen #(
   parameter int PERIOD = 25_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick,
   output logic half_tick
);

   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
   localparam logic [CW-1:0] HALF = CW'(PERIOD / 2 - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
   end

   // A synchronous clear in the same cycle swallows any pending tick.
   assign tick      = en && !clr && (cnt == LAST);
   assign half_tick = en && !clr && ((cnt == LAST) || (cnt == HALF));

endmodule

// File: rtl/timer_ctrl.sv
// Two-digit BCD countdown with start/pause/clear, expiry pulse and frame-synchronous
// display buffer. Define TIMER_CTRL_BLINK_EN to blink the display while expired.
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int CLK_HZ = 25_000_000
) (
   input  logic       i_clk_25,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_pause,
   input  logic       i_clear,
   input  logic [3:0] i_load_ten,
   input  logic [3:0] i_load_one,
   input  logic       i_frame,
   output logic [3:0] o_ten,
   output logic [3:0] o_one,
   output logic       o_blank,
   output logic       o_running,
   output logic       o_timeout
);

   timer_state_t state, nxt_state;
   bcd_t         ten, one, nxt_ten, nxt_one;
   bcd_t         ld_ten, ld_one;
   logic         expire;
   logic         blank, nxt_blank;
   logic         pre_en, pre_clr, tick, half_tick;

   assign ld_ten  = bcd_clamp(i_load_ten);
   assign ld_one  = bcd_clamp(i_load_one);
   assign pre_clr = i_clear | i_start;

`ifdef TIMER_CTRL_BLINK_EN
   assign pre_en = (state == ST_RUN) || (state == ST_EXPIRED);
`else
   assign pre_en = (state == ST_RUN);
`endif

   tick_gen #(
      .PERIOD (CLK_HZ)
   ) u_tick (
      .clk       (i_clk_25),
      .rst       (i_rst),
      .en        (pre_en),
      .clr       (pre_clr),
      .tick      (tick),
      .half_tick (half_tick)
   );

   // Priority: clear > start > pause > tick; a tick with pause decrements first.
   always_comb begin
      nxt_state = state;
      nxt_ten   = ten;
      nxt_one   = one;
      expire    = 1'b0;
      if (i_clear) begin
         nxt_state = ST_IDLE;
         nxt_ten   = '0;
         nxt_one   = '0;
      end else if (i_start) begin
         nxt_ten = ld_ten;
         nxt_one = ld_one;
         if (ld_ten == '0 && ld_one == '0) begin
            nxt_state = ST_EXPIRED;
            expire    = 1'b1;
         end else begin
            nxt_state = ST_RUN;
         end
      end else begin
         if (state == ST_RUN && tick) begin
            if (one != '0) begin
               nxt_one = one - 1'b1;
            end else begin
               nxt_ten = ten - 1'b1;
               nxt_one = BCD_MAX;
            end
            if (ten == '0 && one == 4'd1) begin
               nxt_state = ST_EXPIRED;
               expire    = 1'b1;
            end
         end
         // Reaching 00 wins over a coincident pause: the timer expires.
         if (i_pause && !expire) begin
            if (state == ST_RUN)
               nxt_state = ST_PAUSE;
            else if (state == ST_PAUSE)
               nxt_state = ST_RUN;
         end
      end
   end

`ifdef TIMER_CTRL_BLINK_EN
   // Blank starts at 1 on every entry to EXPIRED, then flips each half period.
   always_comb begin
      nxt_blank = 1'b0;
      if (nxt_state == ST_EXPIRED)
         nxt_blank = (state == ST_EXPIRED && !pre_clr) ? (blank ^ half_tick) : 1'b1;
   end
`else
   assign nxt_blank = 1'b0;
`endif

   always_ff @(posedge i_clk_25 or posedge i_rst) begin
      if (i_rst) begin
         state     <= ST_IDLE;
         ten       <= '0;
         one       <= '0;
         blank     <= 1'b0;
         o_ten     <= '0;
         o_one     <= '0;
         o_blank   <= 1'b0;
         o_running <= 1'b0;
         o_timeout <= 1'b0;
      end else begin
         state     <= nxt_state;
         ten       <= nxt_ten;
         one       <= nxt_one;
         blank     <= nxt_blank;
         o_running <= (nxt_state == ST_RUN);
         o_timeout <= expire;
         if (i_frame) begin
            o_ten   <= ten;
            o_one   <= one;
            o_blank <= blank;
         end
      end
   end

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios followed by random pulses, all checked
// cycle by cycle against a seconds-remaining reference model.
module tb_timer_ctrl;

   localparam int HZ = 10;
`ifdef TIMER_CTRL_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

   logic       i_clk_25 = 1'b0;
   logic       i_rst = 1'b1;
   logic       i_start = 1'b0, i_pause = 1'b0, i_clear = 1'b0, i_frame = 1'b0;
   logic [3:0] i_load_ten = '0, i_load_one = '0;
   logic [3:0] o_ten, o_one;
   logic       o_blank, o_running, o_timeout;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: whole seconds remaining plus phase within the current second.
   int mode, secs, phase, exp_age;
   int d_ten, d_one;
   bit d_blank, m_to;

   always #5 i_clk_25 = ~i_clk_25;

   timer_ctrl #(.CLK_HZ(HZ)) dut (
      .i_clk_25   (i_clk_25),
      .i_rst      (i_rst),
      .i_start    (i_start),
      .i_pause    (i_pause),
      .i_clear    (i_clear),
      .i_load_ten (i_load_ten),
      .i_load_one (i_load_one),
      .i_frame    (i_frame),
      .o_ten      (o_ten),
      .o_one      (o_one),
      .o_blank    (o_blank),
      .o_running  (o_running),
      .o_timeout  (o_timeout)
   );

   function automatic bit blank_now();
      return BLINK && (mode == M_EXP) && (((exp_age / (HZ / 2)) % 2) == 0);
   endfunction

   task automatic model_reset();
      mode = M_IDLE; secs = 0; phase = 0; exp_age = 0;
      d_ten = 0; d_one = 0; d_blank = 1'b0; m_to = 1'b0;
   endtask

   task automatic model_edge(bit st, bit pa, bit cl, logic [3:0] lt, logic [3:0] lo, bit fr);
      int lt_i, lo_i;
      lt_i = (lt > 4'd9) ? 9 : int'(lt);
      lo_i = (lo > 4'd9) ? 9 : int'(lo);
      if (fr) begin
         d_ten   = secs / 10;
         d_one   = secs % 10;
         d_blank = blank_now();
      end
      m_to = 1'b0;
      if (cl) begin
         mode = M_IDLE; secs = 0; phase = 0;
      end else if (st) begin
         secs = lt_i * 10 + lo_i; phase = 0; exp_age = 0;
         if (secs == 0) begin mode = M_EXP; m_to = 1'b1; end
         else mode = M_RUN;
      end else begin
         case (mode)
            M_RUN: begin
               if (phase == HZ - 1) begin phase = 0; secs = secs - 1; end
               else phase = phase + 1;
               if (secs == 0) begin mode = M_EXP; m_to = 1'b1; exp_age = 0; end
               else if (pa) mode = M_PAUSE;
            end
            M_PAUSE: if (pa) mode = M_RUN;
            M_EXP:   exp_age = exp_age + 1;
            default: ;
         endcase
      end
   endtask

   task automatic chk(string tag, logic [3:0] got, logic [3:0] exp);
      n_cmp++;
      assert (got === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("ten",     o_ten, 4'(d_ten));
      chk("one",     o_one, 4'(d_one));
      chk("blank",   {3'b0, o_blank},   {3'b0, d_blank});
      chk("running", {3'b0, o_running}, {3'b0, (mode == M_RUN)});
      chk("timeout", {3'b0, o_timeout}, {3'b0, m_to});
   endtask

   task automatic step(bit st, bit pa, bit cl, logic [3:0] lt, logic [3:0] lo, bit fr);
      i_start = st; i_pause = pa; i_clear = cl; i_frame = fr;
      i_load_ten = lt; i_load_one = lo;
      @(posedge i_clk_25);
      model_edge(st, pa, cl, lt, lo, fr);
      #1;
      check_all();
      i_start = 1'b0; i_pause = 1'b0; i_clear = 1'b0; i_frame = 1'b0;
   endtask

   initial begin
      model_reset();
      #23;
      check_all();
      chk("rst_ten", o_ten, 4'd0);
      i_rst = 1'b0;

      // Load 1,2 with a frame every cycle; 12 -> 11 -> 10 -> 09.
      step(1, 0, 0, 4'd1, 4'd2, 1);
      step(0, 0, 0, 4'd1, 4'd2, 1);
      chk("t1_ten_a", o_ten, 4'd1); chk("t1_one_a", o_one, 4'd2);
      repeat (10) step(0, 0, 0, 4'd1, 4'd2, 1);
      chk("t1_one_b", o_one, 4'd1);
      repeat (10) step(0, 0, 0, 4'd1, 4'd2, 1);
      chk("t1_one_c", o_one, 4'd0);
      repeat (10) step(0, 0, 0, 4'd1, 4'd2, 1);
      chk("t1_ten_d", o_ten, 4'd0); chk("t1_one_d", o_one, 4'd9);

      // Load 0,1: expiry after one second, single-cycle timeout.
      step(1, 0, 0, 4'd0, 4'd1, 1);
      repeat (9) step(0, 0, 0, 4'd0, 4'd1, 1);
      chk("t2_to_early", {3'b0, o_timeout}, 4'd0);
      step(0, 0, 0, 4'd0, 4'd1, 1);
      chk("t2_to", {3'b0, o_timeout}, 4'd1);
      chk("t2_run", {3'b0, o_running}, 4'd0);
      step(0, 0, 0, 4'd0, 4'd1, 1);
      chk("t2_to_end", {3'b0, o_timeout}, 4'd0);
      chk("t2_one", o_one, 4'd0);

      // Pause after 4 cycles, hold, resume: decrement lands 6 cycles after resume.
      step(1, 0, 0, 4'd0, 4'd5, 1);
      repeat (3) step(0, 0, 0, 4'd0, 4'd5, 1);
      step(0, 1, 0, 4'd0, 4'd5, 1);
      repeat (30) step(0, 0, 0, 4'd0, 4'd5, 1);
      chk("t3_hold", o_one, 4'd5);
      step(0, 1, 0, 4'd0, 4'd5, 1);
      repeat (6) step(0, 0, 0, 4'd0, 4'd5, 1);
      chk("t3_before", o_one, 4'd5);
      step(0, 0, 0, 4'd0, 4'd5, 1);
      chk("t3_after", o_one, 4'd4);

      // Clamp F,C -> 9,9; then 0,0 expires at once.
      step(1, 0, 0, 4'hF, 4'hC, 1);
      step(0, 0, 0, 4'hF, 4'hC, 1);
      chk("t4_ten", o_ten, 4'd9); chk("t4_one", o_one, 4'd9);
      step(1, 0, 0, 4'd0, 4'd0, 1);
      chk("t4_to", {3'b0, o_timeout}, 4'd1);

      // Frame withheld across the 5 -> 4 change.
      step(1, 0, 0, 4'd0, 4'd5, 1);
      step(0, 0, 0, 4'd0, 4'd5, 1);
      repeat (12) step(0, 0, 0, 4'd0, 4'd5, 0);
      chk("t5_held", o_one, 4'd5);
      step(0, 0, 0, 4'd0, 4'd5, 1);
      chk("t5_commit", o_one, 4'd4);

      // Clear together with start wins.
      step(1, 0, 1, 4'd3, 4'd3, 1);
      step(0, 0, 0, 4'd3, 4'd3, 1);
      chk("t6_ten", o_ten, 4'd0);
      chk("t6_run", {3'b0, o_running}, 4'd0);

      // Asynchronous reset mid-count.
      step(1, 0, 0, 4'd2, 4'd5, 1);
      repeat (7) step(0, 0, 0, 4'd2, 4'd5, 1);
      #2 i_rst = 1'b1;
      #1;
      model_reset();
      chk("t7_ten", o_ten, 4'd0);
      chk("t7_one", o_one, 4'd0);
      chk("t7_run", {3'b0, o_running}, 4'd0);
      #10 i_rst = 1'b0;

      // Expire and dwell; blank pattern is checked by the model each cycle.
      step(1, 0, 0, 4'd0, 4'd1, 1);
      repeat (35) step(0, 0, 0, 4'd0, 4'd1, 1);

      // Random pulses.
      for (int k = 0; k < 1500; k++) begin
         bit st, pa, cl, fr;
         logic [3:0] lt, lo;
         st = ($urandom_range(0, 79) == 0);
         pa = ($urandom_range(0, 24) == 0);
         cl = ($urandom_range(0, 199) == 0);
         fr = ($urandom_range(0, 1) == 0);
         lt = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 2));
         lo = 4'($urandom_range(0, 15));
         step(st, pa, cl, lt, lo, fr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
